ysyx_25040129_wbu: RTL

Write-back/commit stage directly downstream of the load-store stage. It accepts one completed instruction bundle per valid/ready handshake, registers it, and in the following cycle drives the register-file and CSR write ports. It sequences the multi-cycle side effects: ecall trap entry (mepc then mcause), mret return, fence.i I-cache flush, and the front-end PC redirect. It emits one retire pulse per instruction.

---
 rtl/ysyx_25040129_wbu_pkg.sv | 40 ++++
 rtl/ysyx_25040129_wbu_if.sv | 36 +++
 rtl/ysyx_25040129_wbu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_wbu_pkg.sv
// Shared types for the write-back stage: state encoding, CSR constants and
// the instruction bundle handed over by the load-store stage.
package ysyx_25040129_wbu_pkg;

  localparam int REGS_DIG = 5;
  localparam int CSR_DIG  = 12;

  localparam logic [CSR_DIG-1:0] CSR_MEPC       = 12'h341;
  localparam logic [CSR_DIG-1:0] CSR_MCAUSE     = 12'h342;
  localparam logic [31:0]        MCAUSE_ECALL_M = 32'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMMIT,
    S_TRAP_CAUSE,
    S_FLUSH,
    S_REDIRECT
  } wbu_state_e;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         result;
    logic [31:0]         csr_wdata;
    logic                reg_write;
    logic [REGS_DIG-1:0] rd;
    logic                csr_write;
    logic [CSR_DIG-1:0]  csr_addr;
    logic                ecall;
    logic                mret;
    logic                fence_i;
    logic                is_branch;
    logic [31:0]         branch_target;
  } wbu_bundle_t;

  // Plain bundles retire in COMMIT and allow pipelined acceptance.
  function automatic logic is_plain(wbu_bundle_t b);
    return !(b.ecall || b.mret || b.fence_i || b.is_branch);
  endfunction

endpackage

// File: rtl/ysyx_25040129_wbu_if.sv
// LSU -> WBU bundle handshake.
interface ysyx_25040129_wbu_if;
  import ysyx_25040129_wbu_pkg::*;

  logic                is_req_valid_from_lsu;
  logic                is_req_ready_to_lsu;
  logic [31:0]         pc_in_wbu;
  logic [31:0]         result_in_wbu;
  logic [31:0]         csr_wdata_in_wbu;
  logic                reg_write_in_wbu;
  logic [REGS_DIG-1:0] rd_in_wbu;
  logic                csr_write_in_wbu;
  logic [CSR_DIG-1:0]  csr_addr_in_wbu;
  logic                ecall_in_wbu;
  logic                mret_in_wbu;
  logic                fence_i_in_wbu;
  logic                is_branch_in_wbu;
  logic [31:0]         branch_target_in_wbu;

  modport master (
    output is_req_valid_from_lsu, pc_in_wbu, result_in_wbu, csr_wdata_in_wbu,
           reg_write_in_wbu, rd_in_wbu, csr_write_in_wbu, csr_addr_in_wbu,
           ecall_in_wbu, mret_in_wbu, fence_i_in_wbu, is_branch_in_wbu,
           branch_target_in_wbu,
    input  is_req_ready_to_lsu
  );

  modport slave (
    input  is_req_valid_from_lsu, pc_in_wbu, result_in_wbu, csr_wdata_in_wbu,
           reg_write_in_wbu, rd_in_wbu, csr_write_in_wbu, csr_addr_in_wbu,
           ecall_in_wbu, mret_in_wbu, fence_i_in_wbu, is_branch_in_wbu,
           branch_target_in_wbu,
    output is_req_ready_to_lsu
  );

endinterface

// File: rtl/ysyx_25040129_wbu.sv
// Write-back/commit stage: registers one bundle, drives RF/CSR writes and
// sequences trap entry, mret, fence.i flush and the front-end redirect.
module ysyx_25040129_wbu
  import ysyx_25040129_wbu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  ysyx_25040129_wbu_if.slave  lsu,
  input  logic [31:0]         mtvec_in,
  input  logic [31:0]         mepc_in,
  output logic                rf_wen,
  output logic [REGS_DIG-1:0] rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic                csr_wen,
  output logic [CSR_DIG-1:0]  csr_waddr,
  output logic [31:0]         csr_wdata,
  output logic                mret_pulse,
  output logic                icache_flush_req,
  input  logic                icache_flush_done,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  input  logic                redirect_ready,
  output logic                inst_retire
);

  wbu_state_e  state_q, state_d;
  wbu_bundle_t bundle_q, bundle_d, req;
  logic [31:0] tgt_q, tgt_d;
  logic        ready, fire;

  always_comb begin
    req               = '0;
    req.pc            = lsu.pc_in_wbu;
    req.result        = lsu.result_in_wbu;
    req.csr_wdata     = lsu.csr_wdata_in_wbu;
    req.reg_write     = lsu.reg_write_in_wbu;
    req.rd            = lsu.rd_in_wbu;
    req.csr_write     = lsu.csr_write_in_wbu;
    req.csr_addr      = lsu.csr_addr_in_wbu;
    req.ecall         = lsu.ecall_in_wbu;
    req.mret          = lsu.mret_in_wbu;
    req.fence_i       = lsu.fence_i_in_wbu;
    req.is_branch     = lsu.is_branch_in_wbu;
    req.branch_target = lsu.branch_target_in_wbu;
  end

  // Gated by rst_n so ready is low for the whole reset window.
  assign ready = rst_n && ((state_q == S_IDLE) ||
                           ((state_q == S_COMMIT) && is_plain(bundle_q)));
  assign fire  = lsu.is_req_valid_from_lsu && ready;
  assign lsu.is_req_ready_to_lsu = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bundle_q <= '0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      tgt_q    <= tgt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bundle_d         = bundle_q;
    tgt_d            = tgt_q;
    rf_wen           = 1'b0;
    rf_waddr         = '0;
    rf_wdata         = '0;
    csr_wen          = 1'b0;
    csr_waddr        = '0;
    csr_wdata        = '0;
    mret_pulse       = 1'b0;
    icache_flush_req = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    inst_retire      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          bundle_d = req;
          state_d  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (bundle_q.ecall) begin
          csr_wen   = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = bundle_q.pc;
          state_d   = S_TRAP_CAUSE;
        end else begin
          rf_wen     = bundle_q.reg_write && (bundle_q.rd != '0);
          rf_waddr   = rf_wen ? bundle_q.rd : '0;
          rf_wdata   = rf_wen ? bundle_q.result : '0;
          csr_wen    = bundle_q.csr_write;
          csr_waddr  = csr_wen ? bundle_q.csr_addr : '0;
          csr_wdata  = csr_wen ? bundle_q.csr_wdata : '0;
          mret_pulse = bundle_q.mret;
          if (bundle_q.mret) begin
            tgt_d   = mepc_in;
            state_d = S_REDIRECT;
          end else if (bundle_q.fence_i) begin
            tgt_d   = bundle_q.pc + 32'd4;
            state_d = S_FLUSH;
          end else if (bundle_q.is_branch) begin
            tgt_d   = bundle_q.branch_target;
            state_d = S_REDIRECT;
          end else begin
            inst_retire = 1'b1;
            if (fire) begin
              bundle_d = req;
              state_d  = S_COMMIT;
            end else begin
              state_d  = S_IDLE;
            end
          end
        end
      end
      S_TRAP_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = MCAUSE_ECALL_M;
        tgt_d     = mtvec_in;
        state_d   = S_REDIRECT;
      end
      S_FLUSH: begin
        icache_flush_req = 1'b1;
        if (icache_flush_done) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt_q;
        if (redirect_ready) begin
          inst_retire = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
